fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program-counter register.
- Reads the current PC and issues one instruction-memory request per instruction over a req/gnt/rvalid bus.
- Holds the returned word for decode under a valid/ready handshake.
- Writes the next PC back to the PC register via its load port: sequential PC+4, or a redirect target from execute. One instruction in flight; no prefetch.

Parameters:
- INSTR_W, 32, instruction and data width.
- PC_W, 32, PC/address width.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_i  in  PC_W  current PC from the PC register output.
- pcNext_o  out  PC_W  value to load into the PC register.
- setPc_o  out  1  PC load strobe; the PC register loads pcNext_o at the same edge.
- imem_req_o  out  1  memory request valid.
- imem_addr_o  out  PC_W  request address; always equals pc_i.
- imem_gnt_i  in  1  request accepted in this cycle.
- imem_rvalid_i  in  1  response valid; never earlier than the cycle after the grant.
- imem_rdata_i  in  INSTR_W  response data.
- imem_err_i  in  1  bus error, qualified by rvalid.
- instr_o  out  INSTR_W  held instruction.
- instrPc_o  out  PC_W  PC of the held instruction.
- instrFault_o  out  1  held instruction came back with a bus error.
- instrValid_o  out  1  instruction available to decode.
- instrReady_i  in  1  decode accepts the instruction.
- redirect_i  in  1  branch/jump taken; flush.
- redirectPc_i  in  PC_W  redirect target.

Behaviour:
- States: REQ, WAIT, HOLD. Registered flags: drop, instrValid. Registered data: instr, instrPc, instrFault.
- Reset: while rst_i is high at an edge, state<=REQ, drop<=0, instrValid<=0, instr/instrPc/instrFault<=0.
  - Combinational outputs imem_req_o and setPc_o are 0 while rst_i=1.
  - The first request is issued in the first cycle after reset deasserts.
  - Reset mid-transaction abandons it. A late rvalid arriving after reset is ignored because state=REQ.
- REQ:
  - imem_req_o = ~redirect_i.
  - On imem_gnt_i & imem_req_o: latch instrPc<=pc_i, go to WAIT.
  - No gnt: stay in REQ with the address stable.
- WAIT:
  - On imem_rvalid_i with drop=0: instr<=rdata, instrFault<=err, instrValid<=1, go to HOLD.
  - On imem_rvalid_i with drop=1: discard data, clear drop, go to REQ.
- HOLD:
  - instrValid_o=1 and outputs stay stable until handshake or redirect.
  - On instrReady_i & ~redirect_i: setPc_o=1, pcNext_o=instrPc+PC_STEP (mod 2^PC_W, wraps), instrValid<=0, go to REQ.
- Redirect (any state, highest priority):
  - setPc_o=1, pcNext_o=redirectPc_i in the same cycle.
  - REQ: no request is issued that cycle; stay in REQ. The next request uses the new PC.
  - WAIT: set drop<=1 and stay in WAIT. If rvalid arrives in that same cycle, discard it and go straight to REQ (drop stays 0).
  - HOLD: instrValid<=0, go to REQ. An instrReady_i in the same cycle does not count as a delivery; decode is flushed by the same redirect.
  - Redirect while drop=1: retarget only; drop stays 1.
- setPc_o is 0 in every other cycle, so the PC register holds its value.
- Fault: no special handling here; the fault is delivered with the instruction and the PC advances by PC_STEP as normal.
- Throughput: with gnt in the REQ cycle, rvalid in the next cycle, and ready immediate, one instruction per 3 cycles.

Decomposition:
- Shared package holds the state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2) and the PC_STEP constant.
- Single module, no sub-modules.
- Benches instantiate it together with the PC register (reset value 0) for closed-loop tests.

Test Plan:
- Sequential fetch: reset, then memory with 0-wait grant and 1-cycle rvalid; decode always ready.
  - Requests go to addresses 0x0, 0x4, 0x8.
  - instrPc_o matches each address; 3 cycles per instruction.
- Backpressure: hold instrReady_i=0 for 5 cycles while in HOLD.
  - instr_o and instrValid_o stay stable; no setPc_o and no new request.
  - On ready, setPc_o pulses for one cycle with pcNext_o=instrPc+4.
- Redirect in WAIT: redirect_i to 0x100 during WAIT; response 0xDEADBEEF arrives 2 cycles later.
  - Response is dropped; instrValid_o stays 0.
  - Next request address is 0x100.
- Redirect in HOLD with simultaneous instrReady_i: setPc_o loads 0x200, not instrPc+4.
  - instrValid_o falls; next address is 0x200.
- Bus error and wrap-around: rvalid with imem_err_i=1 at PC 0xFFFFFFFC.
  - instrFault_o=1 is delivered.
  - pcNext_o=0x00000000 on handshake.
- Reset mid-WAIT: assert rst_i for 1 cycle during WAIT.
  - instrValid_o=0, state REQ; a late rvalid is ignored.
  - Next request address is 0x0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Fetch stage shared definitions: FSM state encoding
// and the default sequential PC increment.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_PC_STEP = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one request in flight, holds the returned
// word for decode and writes the next PC back to the PC register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned PC_STEP = FETCH_PC_STEP
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [PC_W-1:0]    pcNext_o,
  output logic               setPc_o,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               imem_err_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instrPc_o,
  output logic               instrFault_o,
  output logic               instrValid_o,
  input  logic               instrReady_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirectPc_i
);

  fetch_state_e       state_q, state_d;
  logic               drop_q, drop_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               fault_q, fault_d;

  assign imem_addr_o  = pc_i;
  assign instr_o      = instr_q;
  assign instrPc_o    = ipc_q;
  assign instrFault_o = fault_q;
  assign instrValid_o = valid_q;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    fault_d    = fault_q;
    imem_req_o = 1'b0;
    setPc_o    = 1'b0;
    pcNext_o   = redirect_i ? redirectPc_i
                            : ipc_q + PC_W'(PC_STEP);
    if (!rst_i) begin
      unique case (state_q)
        ST_REQ: begin
          imem_req_o = ~redirect_i;
          if (imem_req_o && imem_gnt_i) begin
            ipc_d   = pc_i;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A redirect coinciding with rvalid kills that
          // response directly, so no drop is left pending.
          if (imem_rvalid_i) begin
            if (drop_q || redirect_i) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              instr_d = imem_rdata_i;
              fault_d = imem_err_i;
              valid_d = 1'b1;
              state_d = ST_HOLD;
            end
          end else if (redirect_i) begin
            drop_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_i || instrReady_i) begin
            valid_d = 1'b0;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
      setPc_o = redirect_i
             || (state_q == ST_HOLD && instrReady_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_REQ;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Closed-loop bench: fetch_unit plus a PC register, scoreboarded
// sequential fetch followed by a cycle table of corner cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_q;
  logic [31:0] pcNext_o;
  logic        setPc_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_err_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instrPc_o;
  logic        instrFault_o;
  logic        instrValid_o;
  logic        instrReady_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirectPc_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pc_i         (pc_q),
    .pcNext_o     (pcNext_o),
    .setPc_o      (setPc_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .imem_err_i   (imem_err_i),
    .instr_o      (instr_o),
    .instrPc_o    (instrPc_o),
    .instrFault_o (instrFault_o),
    .instrValid_o (instrValid_o),
    .instrReady_i (instrReady_i),
    .redirect_i   (redirect_i),
    .redirectPc_i (redirectPc_i)
  );

  always_ff @(posedge clk) begin
    if (rst_i) pc_q <= '0;
    else if (setPc_o) pc_q <= pcNext_o;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        rst, gnt, rv, err, rdy, rd;
    logic [31:0] rdata, rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_set;
    logic [31:0] e_next;
    logic        e_valid;
    logic [31:0] e_ipc, e_instr;
    logic        e_fault;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   gnt_cyc[$];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A5A_0000;
  endfunction

  task automatic add(
    input logic rst, gnt, rv, err, rdy, rd,
    input logic [31:0] rdata, rpc,
    input logic e_req, input logic [31:0] e_addr,
    input logic e_set, input logic [31:0] e_next,
    input logic e_valid, input logic [31:0] e_ipc, e_instr,
    input logic e_fault);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.err = err;
    v.rdy = rdy; v.rd = rd; v.rdata = rdata; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_set = e_set; v.e_next = e_next;
    v.e_valid = e_valid; v.e_ipc = e_ipc;
    v.e_instr = e_instr; v.e_fault = e_fault;
    vt.push_back(v);
  endtask

  task automatic idle_inputs();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = '0; imem_err_i = 1'b0;
    instrReady_i = 1'b0; redirect_i = 1'b0;
    redirectPc_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend;
    logic [31:0] pend_data;
    logic [31:0] exp_addr;
    int          delivered, stall_cnt, cyc;
    exp_t        e;

    // Reset state
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    imem_gnt_i = 1'b1; instrReady_i = 1'b1;
    redirect_i = 1'b1; redirectPc_i = 32'h40;
    #1;
    chk("rst_valid", 32'(instrValid_o), 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_ipc", instrPc_o, 0);
    chk("rst_fault", 32'(instrFault_o), 0);
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_setpc", 32'(setPc_o), 0);
    chk("rst_pc", pc_q, 0);
    idle_inputs();
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Sequential fetch with a 5-cycle backpressure window
    exp_addr = 0; pend = 1'b0; pend_data = '0;
    delivered = 0; stall_cnt = 0;
    for (cyc = 0; cyc < 80 && delivered < 6; cyc++) begin
      imem_gnt_i    = 1'b1;
      imem_rvalid_i = pend;
      imem_rdata_i  = pend ? pend_data : 32'h0;
      imem_err_i    = 1'b0;
      redirect_i    = 1'b0;
      instrReady_i  = !(delivered == 3 && stall_cnt < 5);
      #1;
      pend = 1'b0;
      if (imem_req_o && imem_gnt_i) begin
        chk("seq_addr", imem_addr_o, exp_addr);
        sb.push_back('{exp_addr, mem_word(exp_addr)});
        pend = 1'b1;
        pend_data = mem_word(exp_addr);
        gnt_cyc.push_back(cyc);
        exp_addr += 32'd4;
      end
      if (instrValid_o && instrReady_i) begin
        if (sb.size() == 0) begin
          chk("seq_spurious_valid", 32'(instrValid_o), 0);
        end else begin
          e = sb.pop_front();
          chk("seq_instr", instr_o, e.data);
          chk("seq_ipc", instrPc_o, e.pc);
          chk("seq_fault", 32'(instrFault_o), 0);
          chk("seq_setpc", 32'(setPc_o), 1);
          chk("seq_next", pcNext_o, e.pc + 32'd4);
        end
        delivered++;
      end else begin
        chk("seq_setpc_idle", 32'(setPc_o), 0);
        if (instrValid_o && sb.size() != 0) begin
          stall_cnt++;
          chk("bp_req", 32'(imem_req_o), 0);
          chk("bp_instr", instr_o, sb[0].data);
          chk("bp_ipc", instrPc_o, sb[0].pc);
        end
      end
      @(posedge clk); #1;
    end
    chk("seq_delivered", delivered, 6);
    chk("bp_stall_cycles", stall_cnt, 5);
    chk("seq_sb_empty", sb.size(), 0);
    if (gnt_cyc.size() >= 3) begin
      chk("thru_gap0", gnt_cyc[1] - gnt_cyc[0], 3);
      chk("thru_gap1", gnt_cyc[2] - gnt_cyc[1], 3);
    end else begin
      chk("thru_grants", gnt_cyc.size(), 3);
    end

    // Corner-case cycle table, starting one cycle after reset
    // rst gnt rv err rdy rd rdata rpc | req addr set next v ipc instr f
    add(0,1,0,0,0,0,0,0, 1,32'h0,0,0,0,0,0,0);
    add(0,0,0,0,0,1,0,32'h100, 0,32'h0,1,32'h100,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,32'h100,0,0,0,0,0,0);
    add(0,0,1,0,0,0,32'hDEADBEEF,0, 0,32'h100,0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,0, 1,32'h100,0,0,0,0,0,0);
    add(0,0,1,0,0,0,32'h11110013,0, 0,32'h100,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,32'h100,0,0,1,32'h100,32'h11110013,0);
    add(0,0,0,0,1,1,0,32'h200,
        0,32'h100,1,32'h200,1,32'h100,32'h11110013,0);
    add(0,0,0,0,0,0,0,0, 1,32'h200,0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,0, 1,32'h200,0,0,0,0,0,0);
    add(0,0,1,0,0,0,32'h22220013,0, 0,32'h200,0,0,0,0,0,0);
    add(0,0,0,0,1,0,0,0,
        0,32'h200,1,32'h204,1,32'h200,32'h22220013,0);
    add(0,0,0,0,0,1,0,32'hFFFFFFFC,
        0,32'h204,1,32'hFFFFFFFC,0,0,0,0);
    add(0,1,0,0,0,0,0,0, 1,32'hFFFFFFFC,0,0,0,0,0,0);
    add(0,0,1,1,0,0,32'h0BADF00D,0,
        0,32'hFFFFFFFC,0,0,0,0,0,0);
    add(0,0,0,0,1,0,0,0,
        0,32'hFFFFFFFC,1,32'h0,1,32'hFFFFFFFC,32'h0BADF00D,1);
    add(0,1,0,0,0,0,0,0, 1,32'h0,0,0,0,0,0,0);
    add(0,0,1,0,0,1,32'h33,32'h300, 0,32'h0,1,32'h300,0,0,0,0);
    add(0,1,0,0,0,0,0,0, 1,32'h300,0,0,0,0,0,0);
    add(0,0,1,0,0,0,32'h44440013,0, 0,32'h300,0,0,0,0,0,0);
    add(0,0,0,0,1,0,0,0,
        0,32'h300,1,32'h304,1,32'h300,32'h44440013,0);
    add(0,1,0,0,0,0,0,0, 1,32'h304,0,0,0,0,0,0);
    add(0,0,0,0,0,1,0,32'h400, 0,32'h304,1,32'h400,0,0,0,0);
    add(0,0,0,0,0,1,0,32'h500, 0,32'h400,1,32'h500,0,0,0,0);
    add(0,0,1,0,0,0,32'h55,0, 0,32'h500,0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,0, 1,32'h500,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,32'h500,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0, 0,32'h500,0,0,0,0,0,0);
    add(0,0,1,0,0,0,32'h66,0, 1,32'h0,0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,0, 1,32'h0,0,0,0,0,0,0);
    add(0,0,1,0,0,0,32'h77770013,0, 0,32'h0,0,0,0,0,0,0);
    add(0,0,0,0,1,0,0,0,
        0,32'h0,1,32'h4,1,32'h0,32'h77770013,0);

    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      rst_i         = vt[i].rst;
      imem_gnt_i    = vt[i].gnt;
      imem_rvalid_i = vt[i].rv;
      imem_err_i    = vt[i].err;
      imem_rdata_i  = vt[i].rdata;
      instrReady_i  = vt[i].rdy;
      redirect_i    = vt[i].rd;
      redirectPc_i  = vt[i].rpc;
      #1;
      chk($sformatf("row%0d_req", i),
          32'(imem_req_o), 32'(vt[i].e_req));
      chk($sformatf("row%0d_addr", i),
          imem_addr_o, vt[i].e_addr);
      chk($sformatf("row%0d_setpc", i),
          32'(setPc_o), 32'(vt[i].e_set));
      if (vt[i].e_set)
        chk($sformatf("row%0d_next", i),
            pcNext_o, vt[i].e_next);
      chk($sformatf("row%0d_valid", i),
          32'(instrValid_o), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("row%0d_ipc", i),
            instrPc_o, vt[i].e_ipc);
        chk($sformatf("row%0d_instr", i),
            instr_o, vt[i].e_instr);
        chk($sformatf("row%0d_fault", i),
            32'(instrFault_o), 32'(vt[i].e_fault));
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    rst_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
